// File: rtl/peak_uart_tx.sv
// 8N1 UART transmitter fed from the peak-accumulate stage's tx FIFO.
// Pulls one byte per frame through the TxEnable/DataValid handshake and sends it LSB first.
module peak_uart_tx #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int STOP_BITS     = 1,
    parameter int VALID_TIMEOUT = 4
) (
    input  logic        SysClk,
    input  logic        Reset,
    input  logic        DataReady,
    input  logic        DataValid,
    input  logic [7:0]  DataIn,
    input  logic        UartCts,
    input  logic        ClearError,
    output logic        TxEnable,
    output logic        UartTxd,
    output logic        Busy,
    output logic        Error,
    output logic [15:0] BytesSent
);

    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_REQ   = 6'b000010;
    localparam logic [5:0] S_WAIT  = 6'b000100;
    localparam logic [5:0] S_START = 6'b001000;
    localparam logic [5:0] S_DATA  = 6'b010000;
    localparam logic [5:0] S_STOP  = 6'b100000;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]  TMO_LAST  = 8'(VALID_TIMEOUT);

    logic [5:0]  r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_tmo;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_err;
    logic [15:0] r_bytes;

    logic        w_baud_end;
    logic [7:0]  w_tmo_next;
    logic        w_timeout;

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_tmo_next = r_tmo + 8'd1;
    // Arriving data beats the timeout on the cycle the count is reached.
    assign w_timeout  = (r_state == S_WAIT) && !DataValid && (w_tmo_next == TMO_LAST);

    assign TxEnable  = r_state[1];
    assign Busy      = ~r_state[0];
    assign UartTxd   = r_txd;
    assign Error     = r_err;
    assign BytesSent = r_bytes;

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_tmo   <= 8'd0;
            r_txd   <= 1'b1;
            r_bytes <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (DataReady && UartCts)
                        r_state <= S_REQ;
                end
                S_REQ: begin
                    r_tmo   <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (DataValid) begin
                        r_baud  <= 16'd0;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        r_tmo <= w_tmo_next;
                        if (w_timeout)
                            r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= 16'd0;
                        r_bit   <= 3'd0;
                        r_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_bit   <= 3'd0;
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    // r_bit is reused here to count stop bits.
                    if (w_baud_end) begin
                        r_baud <= 16'd0;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= 3'd0;
                            r_bytes <= r_bytes + 16'd1;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Shift register is pure data and needs no reset.
    always_ff @(posedge SysClk) begin
        if (r_state == S_WAIT && DataValid)
            r_shift <= DataIn;
        else if (r_state == S_DATA && w_baud_end)
            r_shift <= {1'b0, r_shift[7:1]};
    end

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset)
            r_err <= 1'b0;
        else if (w_timeout)
            r_err <= 1'b1;
        else if (ClearError)
            r_err <= 1'b0;
    end

endmodule

// File: tb/tb_peak_uart_tx.sv
// Directed bench for peak_uart_tx: instance a (4 clk/bit, 1 stop) and instance b (3 clk/bit, 2 stop)
// share stimulus; each step checks only the instance under test.
module tb_peak_uart_tx;

    logic        SysClk = 1'b0;
    logic        Reset = 1'b1;
    logic        DataReady = 1'b0;
    logic        DataValid = 1'b0;
    logic [7:0]  DataIn = 8'h00;
    logic        UartCts = 1'b0;
    logic        ClearError = 1'b0;

    logic        TxEnable_a, UartTxd_a, Busy_a, Error_a;
    logic [15:0] BytesSent_a;
    logic        TxEnable_b, UartTxd_b, Busy_b, Error_b;
    logic [15:0] BytesSent_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 SysClk = ~SysClk;

    peak_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .VALID_TIMEOUT(4)) u_dut_a (
        .SysClk(SysClk), .Reset(Reset), .DataReady(DataReady), .DataValid(DataValid),
        .DataIn(DataIn), .UartCts(UartCts), .ClearError(ClearError),
        .TxEnable(TxEnable_a), .UartTxd(UartTxd_a), .Busy(Busy_a), .Error(Error_a),
        .BytesSent(BytesSent_a)
    );

    peak_uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2), .VALID_TIMEOUT(4)) u_dut_b (
        .SysClk(SysClk), .Reset(Reset), .DataReady(DataReady), .DataValid(DataValid),
        .DataIn(DataIn), .UartCts(UartCts), .ClearError(ClearError),
        .TxEnable(TxEnable_b), .UartTxd(UartTxd_b), .Busy(Busy_b), .Error(Error_b),
        .BytesSent(BytesSent_b)
    );

    function automatic logic f_txd(input int w);
        return (w == 0) ? UartTxd_a : UartTxd_b;
    endfunction
    function automatic logic f_txen(input int w);
        return (w == 0) ? TxEnable_a : TxEnable_b;
    endfunction
    function automatic logic f_busy(input int w);
        return (w == 0) ? Busy_a : Busy_b;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        DataReady = 1'b0;
        DataValid = 1'b0;
        UartCts = 1'b0;
        ClearError = 1'b0;
        DataIn = 8'h00;
        tick();
        tick();
        Reset = 1'b1;
        tick();
    endtask

    // Called on the sample just after START is entered; returns on the sample after the frame.
    task automatic check_frame(input int w, input logic [7:0] b, input int drop_at);
        int cpb;
        int nbits;
        int i;
        logic e;
        cpb = (w == 0) ? 4 : 3;
        nbits = (w == 0) ? 10 : 11;
        i = 0;
        for (int bi = 0; bi < nbits; bi++) begin
            for (int c = 0; c < cpb; c++) begin
                if (bi == 0) e = 1'b0;
                else if (bi <= 8) e = b[bi-1];
                else e = 1'b1;
                chk1($sformatf("frame%0d_%02h_bit%0d_clk%0d", w, b, bi, c), f_txd(w), e);
                if (c == 0) chk1($sformatf("frame%0d_%02h_busy%0d", w, b, bi), f_busy(w), 1'b1);
                if (drop_at >= 0 && i == drop_at) begin
                    UartCts = 1'b0;
                    DataReady = 1'b0;
                end
                if (drop_at >= 0 && i == drop_at + 12) UartCts = 1'b1;
                i++;
                tick();
            end
        end
    endtask

    // Called on a sample where the DUT sits in IDLE.
    task automatic xfer(input int w, input logic [7:0] b, input int drop_at);
        chk1("idle_txd", f_txd(w), 1'b1);
        chk1("idle_busy", f_busy(w), 1'b0);
        DataReady = 1'b1;
        UartCts = 1'b1;
        tick();
        chk1("req_txen", f_txen(w), 1'b1);
        chk1("req_txd", f_txd(w), 1'b1);
        chk1("req_busy", f_busy(w), 1'b1);
        DataValid = 1'b1;
        DataIn = b;
        tick();
        chk1("wait_txen", f_txen(w), 1'b0);
        chk1("wait_txd", f_txd(w), 1'b1);
        tick();
        DataValid = 1'b0;
        DataIn = 8'h00;
        check_frame(w, b, drop_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        do_reset();
        chk1("rst_txd", UartTxd_a, 1'b1);
        chk1("rst_txen", TxEnable_a, 1'b0);
        chk1("rst_busy", Busy_a, 1'b0);
        chk1("rst_err", Error_a, 1'b0);
        chk16("rst_bytes", BytesSent_a, 16'h0000);

        // Single byte 0xA5
        xfer(0, 8'hA5, -1);
        DataReady = 1'b0;
        chk16("t1_bytes", BytesSent_a, 16'h0001);
        chk1("t1_busy", Busy_a, 1'b0);
        tick();
        chk1("t1_idle_busy", Busy_a, 1'b0);
        chk1("t1_idle_txen", TxEnable_a, 1'b0);

        // Three bytes back-to-back; xfer checks the 3-cycle high gap
        do_reset();
        xfer(0, 8'hFF, -1);
        xfer(0, 8'h20, -1);
        xfer(0, 8'h3C, -1);
        DataReady = 1'b0;
        chk16("t2_bytes", BytesSent_a, 16'h0003);
        tick();
        chk1("t2_busy", Busy_a, 1'b0);

        // DataValid timeout
        do_reset();
        DataReady = 1'b1;
        UartCts = 1'b1;
        tick();
        chk1("t3_txen", TxEnable_a, 1'b1);
        DataReady = 1'b0;
        tick();
        chk1("t3_err_w0", Error_a, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk1($sformatf("t3_err_w%0d", k), Error_a, 1'b0);
            chk1($sformatf("t3_txd_w%0d", k), UartTxd_a, 1'b1);
            chk1($sformatf("t3_busy_w%0d", k), Busy_a, 1'b1);
        end
        tick();
        chk1("t3_err_set", Error_a, 1'b1);
        chk1("t3_busy_idle", Busy_a, 1'b0);
        chk1("t3_txd_idle", UartTxd_a, 1'b1);
        chk16("t3_bytes", BytesSent_a, 16'h0000);
        DataValid = 1'b1;
        DataIn = 8'h55;
        tick();
        DataValid = 1'b0;
        chk1("t3_stray_dv_busy", Busy_a, 1'b0);
        chk1("t3_stray_dv_err", Error_a, 1'b1);
        ClearError = 1'b1;
        tick();
        ClearError = 1'b0;
        chk1("t3_err_clr", Error_a, 1'b0);
        // Timeout and ClearError together: set wins
        DataReady = 1'b1;
        tick();
        DataReady = 1'b0;
        tick();
        tick();
        tick();
        tick();
        ClearError = 1'b1;
        tick();
        ClearError = 1'b0;
        chk1("t3_set_wins", Error_a, 1'b1);
        ClearError = 1'b1;
        tick();
        ClearError = 1'b0;
        chk1("t3_err_clr2", Error_a, 1'b0);
        // DataValid on the timeout cycle: data wins
        DataReady = 1'b1;
        tick();
        DataReady = 1'b0;
        tick();
        tick();
        tick();
        tick();
        DataValid = 1'b1;
        DataIn = 8'h96;
        tick();
        DataValid = 1'b0;
        chk1("t3_data_wins_err", Error_a, 1'b0);
        check_frame(0, 8'h96, -1);
        chk16("t3_data_wins_bytes", BytesSent_a, 16'h0001);

        // CTS low blocks reads
        do_reset();
        DataReady = 1'b1;
        UartCts = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk1($sformatf("t4_txen%0d", k), TxEnable_a, 1'b0);
            chk1($sformatf("t4_txd%0d", k), UartTxd_a, 1'b1);
            chk1($sformatf("t4_busy%0d", k), Busy_a, 1'b0);
        end
        xfer(0, 8'hC3, 10);
        chk16("t4_bytes", BytesSent_a, 16'h0001);
        tick();
        chk1("t4_after_txen", TxEnable_a, 1'b0);
        chk1("t4_after_busy", Busy_a, 1'b0);

        // Reset during data bit 3 of 0x5A
        do_reset();
        DataReady = 1'b1;
        UartCts = 1'b1;
        tick();
        DataValid = 1'b1;
        DataIn = 8'h5A;
        DataReady = 1'b0;
        tick();
        tick();
        DataValid = 1'b0;
        chk1("t5_start", UartTxd_a, 1'b0);
        repeat (17) tick();
        chk1("t5_bit3_busy", Busy_a, 1'b1);
        chk1("t5_bit3_txd", UartTxd_a, 1'b1);
        #1;
        Reset = 1'b0;
        #1;
        chk1("t5_rst_txd", UartTxd_a, 1'b1);
        chk1("t5_rst_busy", Busy_a, 1'b0);
        chk1("t5_rst_txen", TxEnable_a, 1'b0);
        chk16("t5_rst_bytes", BytesSent_a, 16'h0000);
        @(negedge SysClk);
        Reset = 1'b1;
        tick();
        xfer(0, 8'h81, -1);
        DataReady = 1'b0;
        chk16("t5_bytes", BytesSent_a, 16'h0001);

        // Two stop bits, 3 clk/bit, counter wrap
        do_reset();
        force u_dut_b.r_bytes = 16'hFFFF;
        tick();
        release u_dut_b.r_bytes;
        tick();
        chk16("t6_preload", BytesSent_b, 16'hFFFF);
        xfer(1, 8'h3C, -1);
        DataReady = 1'b0;
        chk16("t6_wrap", BytesSent_b, 16'h0000);
        chk1("t6_busy", Busy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_uart_tx.md
Name: peak_uart_tx

Overview:
Downstream consumer of the peak-accumulate stage's byte output.
- Pulls one byte at a time from the stage's tx FIFO using the existing DataReady / TxEnable / DataValid / DataOut handshake.
- Serializes each byte as 8N1 UART, LSB first, to the host link.
- Start/stop marker words already sit in the byte stream; the block passes them through and does not interpret them.

Parameters:
CLKS_PER_BIT, 868, SysClk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
STOP_BITS, 1, number of stop bits; 1 or 2.
VALID_TIMEOUT, 4, cycles to wait for DataValid after the read strobe before flagging an error.

Ports:
SysClk  in  1  system clock; all logic is on the rising edge.
Reset  in  1  asynchronous, active-low reset (0 = reset).
DataReady  in  1  upstream tx FIFO has data (non-empty, or a word is in flight).
DataValid  in  1  upstream read data valid; asserted one or more cycles after TxEnable.
DataIn  in  8  upstream read data; sampled only when DataValid=1 in WAIT_VALID.
UartCts  in  1  host clear-to-send, active-high; checked only in IDLE.
ClearError  in  1  synchronous clear of the Error flag.
TxEnable  out  1  upstream FIFO read strobe; exactly one cycle per byte.
UartTxd  out  1  serial output, registered; idle level is high.
Busy  out  1  high in every state except IDLE.
Error  out  1  sticky flag: DataValid timeout occurred.
BytesSent  out  16  count of completed bytes; wraps modulo 2^16.

Behaviour:
- Reset asserted (async): state=IDLE, UartTxd=1, TxEnable=0, Busy=0, Error=0, BytesSent=0, baud and bit counters=0.
- States, one-hot: IDLE, REQ, WAIT_VALID, START, DATA, STOP.
- IDLE:
  - UartTxd=1.
  - If DataReady & UartCts: go to REQ; otherwise stay.
- REQ:
  - TxEnable=1, decoded from the state register, for exactly one cycle.
  - Then go to WAIT_VALID; clear the timeout counter.
- WAIT_VALID:
  - If DataValid=1: load the shift register with DataIn and go to START; reset the baud counter.
  - Otherwise increment the timeout counter. When it reaches VALID_TIMEOUT: set Error=1 and go to IDLE. No byte is sent and BytesSent is unchanged.
  - DataValid on the same cycle the timeout count is reached: the data wins; Error is not set.
- START: UartTxd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - UartTxd=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right at each bit end.
  - After bit index 7 completes, go to STOP.
- STOP:
  - UartTxd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: BytesSent += 1, go to IDLE.
- Inter-byte gap: minimum 3 SysClk cycles from stop-bit end to the next start bit (IDLE, REQ, WAIT_VALID with DataValid=1).
- UartCts and DataReady are sampled only in IDLE. Deasserting them mid-byte has no effect on the byte in progress.
- DataValid outside WAIT_VALID is ignored. No capture, no error.
- ClearError:
  - Clears Error the next cycle.
  - If a timeout fires in the same cycle, set wins and Error stays 1.
- Counter widths: baud counter 16 bits, bit index 3 bits, timeout counter 8 bits.
- UartTxd changes only on baud boundaries or state entry; it is glitch-free.
- Reset asserted mid-byte: immediate abort, UartTxd=1. The partial byte is lost and not counted.
- Bit period is exactly CLKS_PER_BIT cycles. Total frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles.

Test Plan:
1. CLKS_PER_BIT=4, STOP_BITS=1, DataReady=1, UartCts=1, DataValid one cycle after TxEnable with DataIn=0xA5:
   - TxEnable pulses for one cycle.
   - UartTxd = 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles.
   - BytesSent=1, Busy low afterwards.
2. Three bytes 0xFF, 0x20, 0x3C supplied back-to-back:
   - Three frames in order.
   - Exactly 3 idle cycles between the stop-bit end and the next start bit.
   - BytesSent=3.
3. DataValid never asserted after TxEnable:
   - Error=1 four cycles after WAIT_VALID is entered; UartTxd stays 1; BytesSent=0.
   - ClearError pulse: Error=0 on the next cycle.
4. UartCts=0 while DataReady=1: no TxEnable, UartTxd=1, Busy=0.
   - Raise UartCts mid-byte on a later run: the in-flight frame is unchanged.
5. Assert Reset (low) during DATA bit 3 of 0x5A:
   - UartTxd=1, Busy=0, BytesSent unchanged, all immediately.
   - After release, the next byte 0x81 is transmitted correctly.
6. STOP_BITS=2, CLKS_PER_BIT=3: stop high for 6 cycles; BytesSent wraps 0xFFFF→0x0000 (counter preloaded by force).
